cs_acq: RTL

- Acquisition scheduler inside the cs control block. It sequences one ADC sample per fs_adc tick: ADC read, then ADC-to-fifod transfer.
- After adc_cnt samples it launches one Ethernet packet: fifod-to-MAC transfer, then UDP transmit.
- All stages are driven through fs_*/fd_* (start/done) flag handshakes. It reports overruns, handshake timeouts and a packet count.

---
 rtl/cs_pkg.sv | 22 ++
 rtl/cs_acq_if.sv | 22 ++
 rtl/cs_acq_wdt.sv | 31 +++
 rtl/cs_acq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the cs acquisition scheduler: state encoding,
// overrun saturation value and default watchdog limit.
package cs_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        READ = 3'd2,
        FIFO = 3'd3,
        PACK = 3'd4,
        SEND = 3'd5
    } state_t;

    localparam logic [7:0]  OVR_MAX     = 8'hFF;
    localparam int unsigned TIMEOUT_DEF = 4096;

    // States that drive an fs_* start flag and wait for its fd_* done.
    function automatic logic is_hs(state_t s);
        return (s == READ) || (s == FIFO) || (s == PACK) || (s == SEND);
    endfunction

endpackage

// File: rtl/cs_acq_if.sv
// Start/done flag handshakes between the acquisition scheduler (master)
// and the ADC, FIFO, MAC and UDP stages (slave).
interface cs_acq_if;
    logic fs_adc_read;
    logic fd_adc_read;
    logic fs_adc_fifo;
    logic fd_adc_fifo;
    logic fs_fifod2mac;
    logic fd_fifod2mac;
    logic fs_udp_tx;
    logic fd_udp_tx;

    modport master (
        output fs_adc_read, fs_adc_fifo, fs_fifod2mac, fs_udp_tx,
        input  fd_adc_read, fd_adc_fifo, fd_fifod2mac, fd_udp_tx
    );

    modport slave (
        input  fs_adc_read, fs_adc_fifo, fs_fifod2mac, fs_udp_tx,
        output fd_adc_read, fd_adc_fifo, fd_fifod2mac, fd_udp_tx
    );
endinterface

// File: rtl/cs_acq_wdt.sv
// Handshake watchdog: counts cycles spent in a handshake state and flags
// expiry on the TIMEOUT-th cycle. Cleared whenever the FSM changes state.
module cs_acq_wdt
    import cs_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = 13
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    // cycle counter, zero on the first cycle of every state
    always_ff @(posedge sys_clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/cs_acq.sv
// Acquisition scheduler: one ADC read + FIFO transfer per sample tick, and
// one MAC transfer + UDP transmit every adc_cnt samples.
// Optional watchdog on every handshake stage: define CS_ACQ_TIMEOUT_EN.
module cs_acq
    import cs_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = 13
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        run,
    input  logic        fs_adc,
    input  logic [7:0]  adc_cnt,
    input  logic        fifod_full,
    cs_acq_if.master    hs,
    output logic        busy,
    output logic        err_timeout,
    output logic [7:0]  ovr_cnt,
    output logic [15:0] pkt_cnt
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] smp_cnt;
    logic       pend;
    logic       run_prev;
    logic [7:0] adc_eff;
    logic       last_smp;
    logic       tick;
    logic       hs_done;
    logic       expire;
    logic       abort;
    logic       run_rise;

    assign adc_eff  = (adc_cnt == 8'd0) ? 8'd1 : adc_cnt;
    assign last_smp = (smp_cnt + 8'd1) == adc_eff;
    assign tick     = fs_adc | pend;
    assign run_rise = run & ~run_prev;
    // a done in the same cycle as expiry completes the stage normally
    assign abort    = expire & ~hs_done;

    // done flag of the stage currently being driven
    always_comb begin
        hs_done = 1'b0;
        case (state)
            READ:    hs_done = hs.fd_adc_read;
            FIFO:    hs_done = hs.fd_adc_fifo;
            PACK:    hs_done = hs.fd_fifod2mac;
            SEND:    hs_done = hs.fd_udp_tx;
            default: hs_done = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (run) state_nx = WAIT;
            WAIT: begin
                if (!run) begin
                    state_nx = IDLE;
                end else if (tick && !fifod_full) begin
                    state_nx = READ;
                end
            end
            READ: begin
                if (hs_done)    state_nx = FIFO;
                else if (abort) state_nx = IDLE;
            end
            FIFO: begin
                if (hs_done)    state_nx = last_smp ? PACK : WAIT;
                else if (abort) state_nx = IDLE;
            end
            PACK: begin
                if (hs_done)    state_nx = SEND;
                else if (abort) state_nx = IDLE;
            end
            SEND: begin
                if (hs_done)    state_nx = WAIT;
                else if (abort) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // start flags are decoded straight from the state register
    always_comb begin
        hs.fs_adc_read  = (state == READ);
        hs.fs_adc_fifo  = (state == FIFO);
        hs.fs_fifod2mac = (state == PACK);
        hs.fs_udp_tx    = (state == SEND);
        busy            = is_hs(state);
    end

    // sample counter, pending tick, overrun and packet counters
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            smp_cnt  <= 8'd0;
            pend     <= 1'b0;
            ovr_cnt  <= 8'd0;
            pkt_cnt  <= 16'd0;
            run_prev <= 1'b0;
        end else begin
            run_prev <= run;
            case (state)
                IDLE: begin
                    smp_cnt <= 8'd0;
                    pend    <= 1'b0;
                    if (run_rise) ovr_cnt <= 8'd0;
                end
                WAIT: begin
                    pend <= 1'b0;
                    if (run && tick && fifod_full && ovr_cnt != OVR_MAX) begin
                        ovr_cnt <= ovr_cnt + 8'd1;
                    end
                end
                default: begin
                    if (abort) begin
                        pend    <= 1'b0;
                        smp_cnt <= 8'd0;
                    end else begin
                        if (fs_adc) begin
                            pend <= 1'b1;
                            if (pend && ovr_cnt != OVR_MAX) ovr_cnt <= ovr_cnt + 8'd1;
                        end
                        if (state == FIFO && hs_done) begin
                            smp_cnt <= last_smp ? 8'd0 : smp_cnt + 8'd1;
                        end
                        if (state == SEND && hs_done) pkt_cnt <= pkt_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

`ifdef CS_ACQ_TIMEOUT_EN
    logic err_q;
    logic wdt_clr;

    assign wdt_clr     = (state_nx != state);
    assign err_timeout = err_q;

    cs_acq_wdt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdt (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (wdt_clr),
        .en      (busy),
        .expire  (expire)
    );

    // sticky timeout flag, cleared by a fresh run request
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end else if (state == IDLE && run_rise) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign expire      = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = ^{TIMEOUT, TO_W};
`endif

endmodule
